// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
// Holds the default bus widths, the port-select encoding used between the
// fairness selector and the request mux, and the hold-counter width.
package dmem_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned DATA_W_DEF = 16;

    // MAX_HOLD is limited to 1..15, so four bits always suffice.
    localparam int unsigned HOLD_W = 4;

    typedef enum logic [1:0] {
        SEL_NONE = 2'b00,
        SEL_A    = 2'b01,
        SEL_B    = 2'b10
    } sel_e;

endpackage

// File: rtl/dmem_fair_sel.sv
// Grant decision for the two memory requesters.
// Port A (core MEM stage) has priority. A hold counter tracks consecutive A
// grants taken while B waits; once it reaches MAX_HOLD, B wins the next
// contested cycle.
// Ports:
//   clk, rst_n   clock and synchronous active-low reset
//   a_req, b_req request lines of the two ports
//   sel          combinational select code (SEL_NONE / SEL_A / SEL_B)
module dmem_fair_sel
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a_req,
    input  logic b_req,
    output sel_e sel
);

    localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);

    logic [HOLD_W-1:0] hold_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_d;

    // While reset is asserted no port is selected, which also blocks any write.
    always_comb begin
        sel        = SEL_NONE;
        hold_cnt_d = '0;
        if (rst_n) begin
            if (a_req && b_req) begin
                sel = (hold_cnt_q == MAX_HOLD_C) ? SEL_B : SEL_A;
            end else if (a_req) begin
                sel = SEL_A;
            end else if (b_req) begin
                sel = SEL_B;
            end
        end
        // Only an A grant with B left waiting advances the count; anything
        // else means B is being served or has no demand.
        if (sel == SEL_A && b_req) begin
            hold_cnt_d = (hold_cnt_q == MAX_HOLD_C) ? hold_cnt_q : hold_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing a single-port data memory between the core (port A) and
// the loader/debug master (port B).
// One access is granted per cycle; the granted port's request is muxed onto
// the memory bus and read data is returned one cycle later through
// registered rvalid/rdata outputs per port.
// Ports:
//   clk, rst_n                 clock and synchronous active-low reset
//   a_* / b_*                  requester interfaces (req, we, addr, wdata in;
//                              gnt comb out; rvalid, rdata registered out)
//   mem_write/address/write_data  memory request bus
//   mem_read_data              memory combinational read data
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    sel_e sel;

    logic              a_rvalid_q, a_rvalid_d;
    logic              b_rvalid_q, b_rvalid_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

    dmem_fair_sel #(
        .MAX_HOLD (MAX_HOLD)
    ) u_fair_sel (
        .clk   (clk),
        .rst_n (rst_n),
        .a_req (a_req),
        .b_req (b_req),
        .sel   (sel)
    );

    // Request mux: an idle bus is driven to zero so the memory sees a
    // quiet, deterministic address when nobody is granted.
    always_comb begin
        a_gnt          = 1'b0;
        b_gnt          = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        unique case (sel)
            SEL_A: begin
                a_gnt          = 1'b1;
                mem_write      = a_we;
                mem_address    = a_addr;
                mem_write_data = a_wdata;
            end
            SEL_B: begin
                b_gnt          = 1'b1;
                mem_write      = b_we;
                mem_address    = b_addr;
                mem_write_data = b_wdata;
            end
            default: ;
        endcase
    end

    // Read responses: a granted read captures the memory output; rdata
    // otherwise keeps its last value while rvalid drops.
    always_comb begin
        a_rvalid_d = a_gnt && !a_we;
        b_rvalid_d = b_gnt && !b_we;
        a_rdata_d  = a_rvalid_d ? mem_read_data : a_rdata_q;
        b_rdata_d  = b_rvalid_d ? mem_read_data : b_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
        end
    end

    assign a_rvalid = a_rvalid_q;
    assign b_rvalid = b_rvalid_q;
    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed-vector bench for dmem_arbiter with a behavioural 256-word memory.
// Grants and bus values are checked in the issuing cycle; expected read
// responses are queued at issue time and matched by an independent monitor.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        a_req, a_we, b_req, b_we;
    logic [15:0] a_addr, a_wdata, b_addr, b_wdata;
    logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [15:0] a_rdata, b_rdata;
    logic        mem_write;
    logic [15:0] mem_address, mem_write_data, mem_read_data;

    logic [15:0] tb_mem [256];

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } resp_t;

    resp_t a_q[$];
    resp_t b_q[$];

    int cyc = 0;
    int checks = 0;
    int fails = 0;

    dmem_arbiter #(
        .ADDR_W   (16),
        .DATA_W   (16),
        .MAX_HOLD (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .a_req          (a_req),
        .a_we           (a_we),
        .a_addr         (a_addr),
        .a_wdata        (a_wdata),
        .a_gnt          (a_gnt),
        .a_rvalid       (a_rvalid),
        .a_rdata        (a_rdata),
        .b_req          (b_req),
        .b_we           (b_we),
        .b_addr         (b_addr),
        .b_wdata        (b_wdata),
        .b_gnt          (b_gnt),
        .b_rvalid       (b_rvalid),
        .b_rdata        (b_rdata),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index used to check response latency.
    always @(posedge clk) cyc <= cyc + 1;

    // Memory decodes only the low 8 address bits.
    assign mem_read_data = tb_mem[mem_address[7:0]];
    always @(posedge clk) begin
        if (mem_write) tb_mem[mem_address[7:0]] <= mem_write_data;
    end

    function automatic void report(input string nm, input logic ok,
                                   input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Monitor: pops the oldest expected response whenever a port shows rvalid.
    always @(negedge clk) begin
        resp_t r;
        if (a_rvalid === 1'b1) begin
            if (a_q.size() == 0) begin
                report("a_rvalid_unexpected", 1'b0, 32'd1, 32'd0);
            end else begin
                r = a_q.pop_front();
                report("a_rdata", a_rdata === r.data, 32'(a_rdata), 32'(r.data));
                report("a_rvalid_cycle", cyc == r.cyc, 32'(cyc), 32'(r.cyc));
            end
        end
        if (b_rvalid === 1'b1) begin
            if (b_q.size() == 0) begin
                report("b_rvalid_unexpected", 1'b0, 32'd1, 32'd0);
            end else begin
                r = b_q.pop_front();
                report("b_rdata", b_rdata === r.data, 32'(b_rdata), 32'(r.data));
                report("b_rvalid_cycle", cyc == r.cyc, 32'(cyc), 32'(r.cyc));
            end
        end
    end

    task automatic applyStimulus(input logic ar, input logic aw, input logic [15:0] aa,
                                 input logic [15:0] ad, input logic br, input logic bw,
                                 input logic [15:0] ba, input logic [15:0] bd);
        a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
        b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    endtask

    // Checks the issuing cycle, queues any expected read response, then
    // advances to just after the next rising edge.
    task automatic checkOutput(input string nm, input logic eag, input logic ebg,
                               input logic emw, input logic [15:0] eaddr,
                               input logic pa, input logic [15:0] ea,
                               input logic pb, input logic [15:0] eb);
        resp_t r;
        @(negedge clk);
        report({nm, "_gnt_we"}, {a_gnt, b_gnt, mem_write} === {eag, ebg, emw},
               32'({a_gnt, b_gnt, mem_write}), 32'({eag, ebg, emw}));
        report({nm, "_addr"}, mem_address === eaddr, 32'(mem_address), 32'(eaddr));
        if (pa) begin
            r.data = ea; r.cyc = cyc + 1;
            a_q.push_back(r);
        end
        if (pb) begin
            r.data = eb; r.cyc = cyc + 1;
            b_q.push_back(r);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) tb_mem[i] = 16'h0000;
        rst_n = 1'b0;
        applyStimulus(1, 1, 16'h0003, 16'hDEAD, 1, 1, 16'h0004, 16'hBEEF);

        // Reset: two cycles with both ports requesting writes.
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            checkOutput("reset", 0, 0, 0, 16'h0000, 0, 0, 0, 0);
            report("reset_rvalid", {a_rvalid, b_rvalid} === 2'b00, 32'({a_rvalid, b_rvalid}), 32'd0);
            report("reset_rdata", {a_rdata, b_rdata} === 32'd0, {a_rdata, b_rdata}, 32'd0);
        end
        rst_n = 1'b1;

        // A write then read, A only.
        applyStimulus(1, 1, 16'h0005, 16'h1234, 0, 0, 16'h0000, 16'h0000);
        checkOutput("a_wr", 1, 0, 1, 16'h0005, 0, 0, 0, 0);
        applyStimulus(1, 0, 16'h0005, 16'h0000, 0, 0, 16'h0000, 16'h0000);
        checkOutput("a_rd", 1, 0, 0, 16'h0005, 1, 16'h1234, 0, 0);
        applyStimulus(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000);
        checkOutput("idle0", 0, 0, 0, 16'h0000, 0, 0, 0, 0);

        // Fairness: A streams writes, B waits with a read of 0x21.
        tb_mem[8'h21] = 16'hBBBB;
        applyStimulus(1, 1, 16'h0020, 16'hAAAA, 1, 0, 16'h0021, 16'h0000);
        for (int i = 0; i < 10; i++) begin
            if (i == 4 || i == 9)
                checkOutput("fair_b", 0, 1, 0, 16'h0021, 0, 0, 1, 16'hBBBB);
            else
                checkOutput("fair_a", 1, 0, 1, 16'h0020, 0, 0, 0, 0);
        end
        applyStimulus(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000);
        checkOutput("idle1", 0, 0, 0, 16'h0000, 0, 0, 0, 0);

        // B preload, then A reads back in reverse order.
        applyStimulus(0, 0, 16'h0000, 16'h0000, 1, 1, 16'h0000, 16'h0253);
        checkOutput("b_wr0", 0, 1, 1, 16'h0000, 0, 0, 0, 0);
        applyStimulus(0, 0, 16'h0000, 16'h0000, 1, 1, 16'h0001, 16'h2022);
        checkOutput("b_wr1", 0, 1, 1, 16'h0001, 0, 0, 0, 0);
        applyStimulus(1, 0, 16'h0001, 16'h0000, 0, 0, 16'h0000, 16'h0000);
        checkOutput("a_rd1", 1, 0, 0, 16'h0001, 1, 16'h2022, 0, 0);
        applyStimulus(1, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000);
        checkOutput("a_rd0", 1, 0, 0, 16'h0000, 1, 16'h0253, 0, 0);

        // Interleaved reads A then B.
        tb_mem[8'h09] = 16'h005A;
        tb_mem[8'h0A] = 16'h0064;
        applyStimulus(1, 0, 16'h0009, 16'h0000, 0, 0, 16'h0000, 16'h0000);
        checkOutput("il_a", 1, 0, 0, 16'h0009, 1, 16'h005A, 0, 0);
        applyStimulus(0, 0, 16'h0000, 16'h0000, 1, 0, 16'h000A, 16'h0000);
        checkOutput("il_b", 0, 1, 0, 16'h000A, 0, 0, 1, 16'h0064);

        // Address wrap and read-after-write: 0x0100 aliases 0x0000.
        applyStimulus(1, 1, 16'h0100, 16'h7777, 0, 0, 16'h0000, 16'h0000);
        checkOutput("wrap_wr", 1, 0, 1, 16'h0100, 0, 0, 0, 0);
        applyStimulus(1, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000);
        checkOutput("wrap_rd", 1, 0, 0, 16'h0000, 1, 16'h7777, 0, 0);

        // Reset mid-read: response already presented survives one cycle only.
        applyStimulus(1, 0, 16'h0001, 16'h0000, 0, 0, 16'h0000, 16'h0000);
        checkOutput("pre_rst_rd", 1, 0, 0, 16'h0001, 1, 16'h2022, 0, 0);
        rst_n = 1'b0;
        applyStimulus(1, 1, 16'h0004, 16'h4444, 1, 1, 16'h0003, 16'h3333);
        checkOutput("mid_rst", 0, 0, 0, 16'h0000, 0, 0, 0, 0);
        rst_n = 1'b1;
        report("post_rst_rvalid", a_rvalid === 1'b0, 32'(a_rvalid), 32'd0);
        report("post_rst_rdata", a_rdata === 16'h0000, 32'(a_rdata), 32'd0);
        checkOutput("post_rst_a", 1, 0, 1, 16'h0004, 0, 0, 0, 0);
        applyStimulus(1, 0, 16'h0003, 16'h0000, 1, 1, 16'h0003, 16'h3333);
        checkOutput("rst_no_wr", 1, 0, 0, 16'h0003, 1, 16'h0000, 0, 0);
        applyStimulus(0, 0, 16'h0000, 16'h0000, 1, 1, 16'h0003, 16'h3333);
        checkOutput("b_after_rst", 0, 1, 1, 16'h0003, 0, 0, 0, 0);
        applyStimulus(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000);
        checkOutput("idle2", 0, 0, 0, 16'h0000, 0, 0, 0, 0);
        checkOutput("idle3", 0, 0, 0, 16'h0000, 0, 0, 0, 0);

        report("a_q_drained", a_q.size() == 0, 32'(a_q.size()), 32'd0);
        report("b_q_drained", b_q.size() == 0, 32'(b_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 16-bit data memory (256 words, combinational read, posedge write) between two requesters.
- Port A is the core's MEM stage. Port B is the loader/debug master used to preload or dump memory.
- Grants at most one access per cycle, drives the memory's write-enable, address and write-data, and returns read data one cycle later through registered outputs.
- A bounded-wait counter guarantees port B progress while A streams accesses.

Parameters:
- ADDR_W, 16, width of requester and memory address buses.
- DATA_W, 16, data width.
- MAX_HOLD, 4, maximum consecutive A grants while B is pending before B is forced a grant; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- a_req  input  1  A requests an access this cycle.
- a_we  input  1  A access is a write (1) or read (0).
- a_addr  input  ADDR_W  A address.
- a_wdata  input  DATA_W  A write data.
- a_gnt  output  1  A access performed this cycle (combinational).
- a_rvalid  output  1  registered; a_rdata holds A's read result.
- a_rdata  output  DATA_W  registered read data for A.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as A, for port B.
- mem_write  output  1  to memory write enable.
- mem_address  output  ADDR_W  to memory address.
- mem_write_data  output  DATA_W  to memory write data.
- mem_read_data  input  DATA_W  from memory combinational read data.

Behaviour:
- **Reset.** While rst_n=0 at a rising edge:
  - hold_cnt=0 and a_rvalid=b_rvalid=0.
  - a_rdata=b_rdata=0.
  - Grant outputs are forced to 0 and mem_write=0 in any cycle where rst_n=0.
- **Grant rule (combinational, same cycle):**
  - Only a_req: A is granted.
  - Only b_req: B is granted.
  - Both requesting: A is granted unless hold_cnt==MAX_HOLD, in which case B is granted.
  - No request: neither port is granted, mem_write=0, and mem_address/mem_write_data are driven 0.
- **Mux.** mem_* mirror the granted port. mem_write = gnt & we of the granted port. a_gnt and b_gnt are never both 1.
- **hold_cnt update (rising edge):**
  - A granted while b_req=1: hold_cnt+1, saturating at MAX_HOLD.
  - B granted, or b_req=0: hold_cnt cleared to 0.
- **Write latency.** A write is committed to memory at the end of the grant cycle. No response pulse is generated for writes.
- **Read latency = 1.**
  - If the granted access is a read, mem_read_data is captured into x_rdata at the rising edge, and x_rvalid=1 for exactly the next cycle.
  - x_rvalid=0 after any cycle without a read grant to that port. x_rdata holds its last value.
- **Requester side.** A requester whose req is not granted must hold req/we/addr/wdata stable until granted. The arbiter keeps no queue.
- **Back-to-back.** Accesses are fully pipelined: one grant per cycle, with no bubble between A→B, B→A or read→write.
- **Read-after-write, same address, consecutive cycles.** The read returns the newly written value. The write commits at edge N, and the read in cycle N+1 sees the updated memory.
- **Address wrap.** The arbiter passes full ADDR_W. The memory decodes only the low 8 bits, so 0x0100 and 0x0000 alias. The arbiter does no range check.
- **Reset mid-operation.** A pending read response is dropped (rvalid=0 next cycle). Any write granted in the reset cycle is suppressed because mem_write is forced 0.

Decomposition:
- A shared package holds:
  - ADDR_W/DATA_W defaults.
  - Port-select encoding: SEL_NONE=2'b00, SEL_A=2'b01, SEL_B=2'b10.
  - MAX_HOLD width constant (4 bits).
- One sub-module, dmem_fair_sel, holds the grant decision and hold_cnt register. It outputs the select code. The top contains the request mux and the registered read-response stages.

Test Plan:
- **Reset.** Hold rst_n=0 for 2 cycles with a_req=b_req=1, a_we=1 → a_gnt=b_gnt=0, mem_write=0, both rvalid=0, rdata=0x0000.
- **A write then read, A only.**
  - Cycle 0: A writes 0x1234 to address 0x0005.
  - Cycle 1: A reads 0x0005.
  - Required: a_gnt=1 both cycles, a_rvalid=1 in cycle 2 with a_rdata=0x1234, b_rvalid=0 throughout.
- **Fairness.** a_req=1 and b_req=1 continuously, MAX_HOLD=4 → grant sequence A,A,A,A,B,A,A,A,A,B; b_gnt asserts on cycles 4 and 9.
- **B preload, then A reads.**
  - B writes 0x0253 to 0x0000 and 0x2022 to 0x0001 on consecutive cycles while a_req=0.
  - A then reads 0x0001, then 0x0000.
  - Required: a_rdata=0x2022, then 0x0253, on consecutive rvalid cycles.
- **Interleaved reads.**
  - Cycle 0: A reads 0x0009, and memory returns 0x005A.
  - Cycle 1: B reads 0x000A, and memory returns 0x0064.
  - Required: a_rvalid only in cycle 1 with a_rdata=0x005A. b_rvalid only in cycle 2 with b_rdata=0x0064.
- **Reset mid-read.**
  - Cycle 0: A read of 0x0001 is granted.
  - Cycle 1: rst_n=0 while A and B request writes.
  - Required: no memory write in cycle 1; a_rvalid=0 in cycle 2; hold_cnt=0 afterwards, so the next contested cycle grants A.
